riscv_fetch_unit: RTL

Instruction fetch stage of the RV32I core. It owns the program counter, issues word fetches to instruction memory through a request/grant/response handshake, and buffers returned instructions for decode. It is the consumer of the execute stage's branch outcome: the ALU `comp` flag and `result` select and compute the redirect target. Wrong-path fetches still in flight are discarded.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 94 +++++++++
 rtl/riscv_fetch_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the RV32I front end.
//   - fetch_state_t    : fetch FSM states (running / draining wrong-path data)
//   - INSTR_BYTES      : size of one instruction word in bytes
//   - RESET_PC_DEFAULT : default first fetch address after reset
// -----------------------------------------------------------------------------
package riscv_pkg;

    typedef enum logic [0:0] {
        F_RUN   = 1'b0,   // issuing requests, keeping responses
        F_DRAIN = 1'b1    // discarding responses to wrong-path requests
    } fetch_state_t;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Small synchronous FIFO. Entry 0 is the head and is a flop, so the
//   head outputs are registered. A pop shifts all entries down by one;
//   a push writes behind the last live entry (after the shift, if both
//   happen in one cycle). Flush empties the FIFO and wins over push/pop.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   i_push, i_data  write an entry (ignored when full with no pop)
//   i_pop           remove the head entry (ignored when empty)
//   i_flush         discard all entries at the next edge
//   o_count         number of live entries
//   o_valid         head entry is live
//   o_data          head entry
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_data
);

    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem      [DEPTH];
    logic [WIDTH-1:0] w_mem_next [DEPTH];
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_next;
    logic [CW-1:0]    w_wr_idx;
    logic             w_pop;
    logic             w_push;

    assign w_pop    = i_pop & (r_count != '0);
    assign w_push   = i_push & ((r_count != CW'(DEPTH)) | w_pop);
    // Write slot is computed after the optional shift-down of a pop.
    assign w_wr_idx = r_count - CW'(w_pop);

    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional update; otherwise a latch is inferred.
        for (int i = 0; i < DEPTH; i++) begin
            w_mem_next[i] = r_mem[i];
        end
        if (w_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                w_mem_next[i] = r_mem[i+1];
            end
        end
        if (w_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_idx == CW'(i)) begin
                    w_mem_next[i] = i_data;
                end
            end
        end

        w_count_next = r_count + CW'(w_push) - CW'(w_pop);
        if (i_flush) begin
            w_count_next = '0;
        end
    end

    // NOTE: the storage is reset too because entry 0 drives the head
    // outputs directly and those must read zero while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_count <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples the pre-edge values.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= w_mem_next[i];
            end
            r_count <= w_count_next;
        end
    end

    assign o_count = r_count;
    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[0];

endmodule

// File: rtl/riscv_fetch_unit.sv
// -----------------------------------------------------------------------------
// riscv_fetch_unit
//   Instruction fetch stage of the RV32I core. Owns the PC, issues word
//   fetches over a request/grant/in-order-response interface and buffers
//   returned instructions for decode. Branch/jump outcomes from execute
//   redirect the PC; responses to wrong-path requests still in flight are
//   dropped while the FSM sits in F_DRAIN.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   imem_req / imem_addr           fetch request and word address
//   imem_gnt                       memory accepted the request
//   imem_rvalid / imem_rdata       in-order response
//   instr_valid / instr / instr_pc buffered instruction to decode
//   instr_ready                    decode consumes the instruction
//   ex_branch, ex_jal, ex_jalr     kind of instruction in execute
//   comp                           ALU comparison flag (branch taken)
//   alu_result                     JALR target from the ALU
//   ex_pc, ex_imm                  PC and offset for branch/JAL targets
// -----------------------------------------------------------------------------
module riscv_fetch_unit
    import riscv_pkg::*;
#(
    parameter int                  IO_WIDTH = 32,
    parameter logic [IO_WIDTH-1:0] RESET_PC = IO_WIDTH'(RESET_PC_DEFAULT),
    parameter int                  DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [IO_WIDTH-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [IO_WIDTH-1:0] imem_rdata,
    output logic                instr_valid,
    output logic [IO_WIDTH-1:0] instr,
    output logic [IO_WIDTH-1:0] instr_pc,
    input  logic                instr_ready,
    input  logic                ex_branch,
    input  logic                ex_jal,
    input  logic                ex_jalr,
    input  logic                comp,
    input  logic [IO_WIDTH-1:0] alu_result,
    input  logic [IO_WIDTH-1:0] ex_pc,
    input  logic [IO_WIDTH-1:0] ex_imm
);

    localparam int                  CW   = $clog2(DEPTH+1);
    localparam logic [IO_WIDTH-1:0] STEP = IO_WIDTH'(INSTR_BYTES);

    fetch_state_t          r_state;
    fetch_state_t          w_state_next;
    logic [IO_WIDTH-1:0]   r_pc;
    logic [IO_WIDTH-1:0]   r_resp_pc;
    logic [CW-1:0]         r_outstanding;
    logic [CW-1:0]         w_outstanding_next;
    logic [CW-1:0]         w_fifo_count;
    logic [CW:0]           w_budget;
    logic [IO_WIDTH-1:0]   w_target;
    logic                  w_redirect;
    logic                  w_grant;
    logic                  w_rsp;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifo_valid;
    logic [2*IO_WIDTH-1:0] w_fifo_head;

    // ---------------------------------------------------------------
    // Redirect decode
    // ---------------------------------------------------------------
    assign w_redirect = ex_jal | ex_jalr | (ex_branch & comp);
    assign w_target   = ex_jalr ? (alu_result & ~IO_WIDTH'(1))
                                : (ex_pc + ex_imm);

    // ---------------------------------------------------------------
    // Handshake qualifiers
    // ---------------------------------------------------------------
    assign w_grant = imem_req & imem_gnt;
    // A response with nothing outstanding is a protocol error; ignore it.
    assign w_rsp   = imem_rvalid & (r_outstanding != '0);
    assign w_push  = w_rsp & (r_state == F_RUN) & ~w_redirect;
    assign w_pop   = w_fifo_valid & instr_ready;

    // Slots already claimed: in-flight requests plus buffered entries.
    // An entry popped this cycle frees its slot now, which lets a single
    // pop re-open issue in the same cycle and sustains one fetch per
    // cycle with a single-cycle memory. Pop implies count >= 1, so the
    // subtraction cannot wrap.
    assign w_budget = {1'b0, r_outstanding} + {1'b0, w_fifo_count}
                    - (CW+1)'(w_pop);

    always_comb begin
        w_outstanding_next = r_outstanding;
        if (w_grant && !w_rsp) begin
            w_outstanding_next = r_outstanding + CW'(1);
        end else if (!w_grant && w_rsp) begin
            w_outstanding_next = r_outstanding - CW'(1);
        end
    end

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= F_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (w_redirect) begin
            // Anything still in flight after this edge is wrong-path.
            w_state_next = (w_outstanding_next != '0) ? F_DRAIN : F_RUN;
        end else begin
            case (r_state)
                F_RUN:   w_state_next = F_RUN;
                F_DRAIN: w_state_next = (w_outstanding_next == '0) ? F_RUN
                                                                   : F_DRAIN;
                default: w_state_next = F_RUN;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        // rst_n gates the request so it stays low for the whole reset
        // window, not just after the first edge.
        imem_req  = rst_n
                  & (r_state == F_RUN)
                  & ~w_redirect
                  & (w_budget < (CW+1)'(DEPTH));
        imem_addr = r_pc;
    end

    // ---------------------------------------------------------------
    // PC, response PC and outstanding counter
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_resp_pc <= RESET_PC;
        end else if (w_redirect) begin
            r_pc      <= w_target;
            r_resp_pc <= w_target;
        end else begin
            if (w_grant) begin
                r_pc <= r_pc + STEP;
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + STEP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
        end else begin
            r_outstanding <= w_outstanding_next;
        end
    end

    // ---------------------------------------------------------------
    // Instruction buffer: {pc, instruction} per entry
    // ---------------------------------------------------------------
    fetch_fifo #(
        .WIDTH (2*IO_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({r_resp_pc, imem_rdata}),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .o_count (w_fifo_count),
        .o_valid (w_fifo_valid),
        .o_data  (w_fifo_head)
    );

    assign instr_valid = w_fifo_valid;
    assign instr_pc    = w_fifo_head[2*IO_WIDTH-1:IO_WIDTH];
    assign instr       = w_fifo_head[IO_WIDTH-1:0];

endmodule
